// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, funct
// codes, ALUOp and ALUControl values.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp and the latched funct field onto the ALU control code.
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        // NOTE: every path of a combinational block must assign every output;
        // a default at the top is the simplest way to guarantee no latch.
        alu_control = ALUCTL_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUCTL_ADD;
                    FUNCT_SUB: alu_control = ALUCTL_SUB;
                    FUNCT_AND: alu_control = ALUCTL_AND;
                    FUNCT_OR:  alu_control = ALUCTL_OR;
                    FUNCT_SLT: alu_control = ALUCTL_SLT;
                    default:   alu_control = ALUCTL_ADD;
                endcase
            end
            default: alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller: Moore FSM plus latched op/funct fields,
// driving the datapath control lines one state per cycle.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        PCEn,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  state,
    output logic        illegal
);

    state_t      current_state, next_state;
    logic [5:0]  op, funct;
    alu_op_t     alu_op;
    logic        pc_write, branch, ir_write, mem_write, reg_write, illegal_raw;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) current_state <= S_FETCH;
        else       current_state <= next_state;
    end

    // The fetched word is only valid during FETCH, so decode runs off these copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            op    <= 6'b000000;
            funct <= 6'b000000;
        end else if (current_state == S_FETCH) begin
            op    <= instr[31:26];
            funct <= instr[5:0];
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (current_state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        illegal_raw = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        alu_op      = ALUOP_ADD;
        case (current_state)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB     = 2'b11;
                illegal_raw = ~op_supported(op);
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables and the illegal pulse are held off for as long as reset is high.
    assign PCEn     = ~reset & (pc_write | (branch & zero));
    assign IRWrite  = ~reset & ir_write;
    assign MemWrite = ~reset & mem_write;
    assign RegWrite = ~reset & reg_write;
    assign illegal  = ~reset & illegal_raw;
    assign state    = current_state;

    aludec u_aludec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (ALUControl)
    );

endmodule
